// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit between ex_mem and mem_wb.
//   Runs LB/LBU/LH/LHU/LW/SB/SH/SW on a req/ack data bus and holds the pipe
//   with stall_from_mem until the access completes. All other ops pass
//   straight through to mem_wb with zero latency.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid, alu_op_i             ex_mem holds a valid instruction / its opcode
//   mem_addr_i, reg2_data_i        effective address, store source data
//   reg_waddr_i/we_i/wdata_i       write-back triple from ex
//   reg_waddr_o/we_o/wdata_o       write-back triple to mem_wb
//   stall_from_mem                 hold ex_mem and all earlier stages
//   dbus_req/we/be/addr/wdata      registered data-bus request
//   dbus_rdata, dbus_ack           data-bus response
// Optional feature macro: UNALIGNED_EXC_EN
//   Misaligned halfword/word accesses raise adel_o/ades_o with badvaddr_o
//   instead of touching the bus.
module mem_lsu #(
   parameter int ALU_OP_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [ALU_OP_W-1:0] alu_op_i,
   input  logic [31:0]         mem_addr_i,
   input  logic [31:0]         reg2_data_i,
   input  logic [4:0]          reg_waddr_i,
   input  logic                reg_we_i,
   input  logic [31:0]         reg_wdata_i,
   output logic [4:0]          reg_waddr_o,
   output logic                reg_we_o,
   output logic [31:0]         reg_wdata_o,
   output logic                stall_from_mem,
   output logic                dbus_req,
   output logic                dbus_we,
   output logic [3:0]          dbus_be,
   output logic [31:0]         dbus_addr,
   output logic [31:0]         dbus_wdata,
   input  logic [31:0]         dbus_rdata,
   input  logic                dbus_ack
`ifdef UNALIGNED_EXC_EN
   ,
   output logic                adel_o,
   output logic                ades_o,
   output logic [31:0]         badvaddr_o
`endif
);
   localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = ALU_OP_W'(8'b1110_0000);
   localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = ALU_OP_W'(8'b1110_0001);
   localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = ALU_OP_W'(8'b1110_0011);
   localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = ALU_OP_W'(8'b1110_0100);
   localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = ALU_OP_W'(8'b1110_0101);
   localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = ALU_OP_W'(8'b1110_1000);
   localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = ALU_OP_W'(8'b1110_1001);
   localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = ALU_OP_W'(8'b1110_1011);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]  r_state;
   logic        r_req;
   logic        r_we;
   logic [3:0]  r_be;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        w_lb, w_lbu, w_lh, w_lhu, w_lw, w_sb, w_sh, w_sw;
   logic        w_is_load, w_is_store, w_half, w_word;
   logic        w_mem_op, w_misalign, w_bus_op;
   logic [3:0]  w_be;
   logic [31:0] w_st_data;
   logic [31:0] w_lane;
   logic [15:0] w_half_lane;
   logic [31:0] w_ld_data;
   assign w_lb  = alu_op_i == EXE_LB_OP;
   assign w_lbu = alu_op_i == EXE_LBU_OP;
   assign w_lh  = alu_op_i == EXE_LH_OP;
   assign w_lhu = alu_op_i == EXE_LHU_OP;
   assign w_lw  = alu_op_i == EXE_LW_OP;
   assign w_sb  = alu_op_i == EXE_SB_OP;
   assign w_sh  = alu_op_i == EXE_SH_OP;
   assign w_sw  = alu_op_i == EXE_SW_OP;
   assign w_is_load  = w_lb | w_lbu | w_lh | w_lhu | w_lw;
   assign w_is_store = w_sb | w_sh | w_sw;
   assign w_half     = w_lh | w_lhu | w_sh;
   assign w_word     = w_lw | w_sw;
   assign w_mem_op   = in_valid & (w_is_load | w_is_store);
`ifdef UNALIGNED_EXC_EN
   assign w_misalign = (w_half & mem_addr_i[0]) | (w_word & (|mem_addr_i[1:0]));
   assign adel_o     = ~rst & w_mem_op & w_is_load & w_misalign;
   assign ades_o     = ~rst & w_mem_op & w_is_store & w_misalign;
   assign badvaddr_o = (adel_o | ades_o) ? mem_addr_i : 32'h0;
`else
   assign w_misalign = 1'b0;
`endif
   // Only accesses that actually go to the bus occupy the FSM and stall.
   assign w_bus_op = w_mem_op & ~w_misalign;
   assign w_be = w_word ? 4'b1111 :
                 w_half ? (mem_addr_i[1] ? 4'b1100 : 4'b0011) :
                          4'b0001 << mem_addr_i[1:0];
   assign w_st_data = w_sw ? reg2_data_i :
                      w_sh ? {2{reg2_data_i[15:0]}} :
                             {4{reg2_data_i[7:0]}};
   // Halfword lane follows addr[1] only, so addr[0] is ignored without the check.
   assign w_lane      = r_rdata >> {mem_addr_i[1:0], 3'b000};
   assign w_half_lane = mem_addr_i[1] ? r_rdata[31:16] : r_rdata[15:0];
   assign w_ld_data = w_lb  ? {{24{w_lane[7]}}, w_lane[7:0]} :
                      w_lbu ? {24'h0, w_lane[7:0]} :
                      w_lh  ? {{16{w_half_lane[15]}}, w_half_lane} :
                      w_lhu ? {16'h0, w_half_lane} :
                              r_rdata;
   assign stall_from_mem = ~rst & w_bus_op & (r_state != DONE);
   assign reg_waddr_o = rst ? 5'h0 : reg_waddr_i;
   assign reg_we_o    = ~rst & (w_mem_op ? (w_is_load & ~w_misalign & (r_state == DONE) & reg_we_i)
                                         : reg_we_i);
   assign reg_wdata_o = rst ? 32'h0 : (w_mem_op & w_is_load) ? w_ld_data : reg_wdata_i;
   assign dbus_req   = r_req;
   assign dbus_we    = r_we;
   assign dbus_be    = r_be;
   assign dbus_addr  = r_addr;
   assign dbus_wdata = r_wdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= 4'h0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_rdata <= 32'h0;
      end else begin
         case (r_state)
            IDLE: if (w_bus_op) begin
               r_req   <= 1'b1;
               r_we    <= w_is_store;
               r_be    <= w_be;
               r_addr  <= {mem_addr_i[31:2], 2'b00};
               r_wdata <= w_st_data;
               r_state <= REQ;
            end
            REQ: if (dbus_ack) begin
               r_rdata <= dbus_rdata;
               r_req   <= 1'b0;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu against a byte-lane reference model.
module tb_mem_lsu;
   localparam logic [7:0] OP_LB   = 8'b1110_0000;
   localparam logic [7:0] OP_LH   = 8'b1110_0001;
   localparam logic [7:0] OP_LW   = 8'b1110_0011;
   localparam logic [7:0] OP_LBU  = 8'b1110_0100;
   localparam logic [7:0] OP_LHU  = 8'b1110_0101;
   localparam logic [7:0] OP_SB   = 8'b1110_1000;
   localparam logic [7:0] OP_SH   = 8'b1110_1001;
   localparam logic [7:0] OP_SW   = 8'b1110_1011;
   localparam logic [7:0] OP_ADDU = 8'b0010_0001;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  alu_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] reg2_data_i;
   logic [4:0]  reg_waddr_i;
   logic        reg_we_i;
   logic [31:0] reg_wdata_i;
   logic [4:0]  reg_waddr_o;
   logic        reg_we_o;
   logic [31:0] reg_wdata_o;
   logic        stall_from_mem;
   logic        dbus_req;
   logic        dbus_we;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;
`ifdef UNALIGNED_EXC_EN
   logic        adel_o;
   logic        ades_o;
   logic [31:0] badvaddr_o;
`endif
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   mem_lsu #(.ALU_OP_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op_i(alu_op_i),
      .mem_addr_i(mem_addr_i), .reg2_data_i(reg2_data_i),
      .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
      .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
      .stall_from_mem(stall_from_mem), .dbus_req(dbus_req), .dbus_we(dbus_we),
      .dbus_be(dbus_be), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
`ifdef UNALIGNED_EXC_EN
      , .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
`endif
   );
   function automatic int m_size(input logic [7:0] op);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 4;
   endfunction
   function automatic bit m_is_load(input logic [7:0] op);
      return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
   endfunction
   function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      if (m_size(op) == 1) return 4'(1 << off);
      if (m_size(op) == 2) return 4'(3 << (off / 2 * 2));
      return 4'hF;
   endfunction
   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] rs2);
      if (m_size(op) == 1) return (rs2 % 256) * 32'h0101_0101;
      if (m_size(op) == 2) return (rs2 % 65536) * 32'h0001_0001;
      return rs2;
   endfunction
   function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
      int off;
      logic [31:0] v;
      off = (m_size(op) == 4) ? 0 : (m_size(op) == 2) ? int'(a % 4) / 2 * 2 : int'(a % 4);
      v = rd >> (8 * off);
      if (m_size(op) == 1) begin
         v = v % 256;
         if (op == OP_LB && v >= 128) v = v - 256;
      end else if (m_size(op) == 2) begin
         v = v % 65536;
         if (op == OP_LH && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction
   // Drives one bus-visible memory op; called just after a rising edge,
   // returns just after the rising edge that ends the DONE cycle.
   task automatic run_mem(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rs2,
                          input logic [31:0] rd, input int lat, input bit we, input logic [4:0] wa,
                          input bit stray_ack);
      bit ld;
      ld = m_is_load(op);
      in_valid = 1'b1; alu_op_i = op; mem_addr_i = a; reg2_data_i = rs2;
      reg_waddr_i = wa; reg_we_i = we; reg_wdata_i = $urandom;
      dbus_ack = stray_ack; dbus_rdata = $urandom;
      @(negedge clk);
      checks++; if (stall_from_mem !== 1'b1) begin errors++; $display("FAIL idle_stall op=%h got %b want 1", op, stall_from_mem); end
      checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL idle_req op=%h got %b want 0", op, dbus_req); end
      checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL idle_we_o op=%h got %b want 0", op, reg_we_o); end
      checks++; if (reg_waddr_o !== wa) begin errors++; $display("FAIL waddr_o got %h want %h", reg_waddr_o, wa); end
      @(posedge clk); #1 dbus_ack = 1'b0;
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL req op=%h cyc=%0d got %b want 1", op, k, dbus_req); end
         checks++; if (dbus_we !== !ld) begin errors++; $display("FAIL bus_we op=%h got %b want %b", op, dbus_we, !ld); end
         checks++; if (dbus_be !== m_be(op, a)) begin errors++; $display("FAIL be op=%h a=%h got %b want %b", op, a, dbus_be, m_be(op, a)); end
         checks++; if (dbus_addr !== (a & ~32'h3)) begin errors++; $display("FAIL bus_addr got %h want %h", dbus_addr, a & ~32'h3); end
         if (!ld) begin
            checks++; if (dbus_wdata !== m_wdata(op, rs2)) begin errors++; $display("FAIL bus_wdata op=%h got %h want %h", op, dbus_wdata, m_wdata(op, rs2)); end
         end
         checks++; if (stall_from_mem !== 1'b1) begin errors++; $display("FAIL req_stall op=%h cyc=%0d got %b want 1", op, k, stall_from_mem); end
         checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL req_we_o op=%h got %b want 0", op, reg_we_o); end
         if (k == lat) begin dbus_ack = 1'b1; dbus_rdata = rd; end
         @(posedge clk); #1 dbus_ack = 1'b0; dbus_rdata = $urandom;
      end
      @(negedge clk);
      checks++; if (stall_from_mem !== 1'b0) begin errors++; $display("FAIL done_stall op=%h got %b want 0", op, stall_from_mem); end
      checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL done_req op=%h got %b want 0", op, dbus_req); end
      checks++; if (reg_we_o !== (ld && we)) begin errors++; $display("FAIL done_we_o op=%h got %b want %b", op, reg_we_o, ld && we); end
      if (ld) begin
         checks++; if (reg_wdata_o !== m_load(op, a, rd)) begin errors++; $display("FAIL load_data op=%h a=%h rd=%h got %h want %h", op, a, rd, reg_wdata_o, m_load(op, a, rd)); end
      end
      @(posedge clk); #1 in_valid = 1'b0; dbus_ack = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; alu_op_i = OP_LW; mem_addr_i = 32'h100;
      reg2_data_i = 32'hFFFF_FFFF; reg_waddr_i = 5'd7; reg_we_i = 1'b1;
      reg_wdata_i = 32'h1234_5678; dbus_rdata = 32'h0; dbus_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (stall_from_mem !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall_from_mem); end
      checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL rst_we_o got %b want 0", reg_we_o); end
      checks++; if (reg_waddr_o !== 5'd0) begin errors++; $display("FAIL rst_waddr_o got %h want 0", reg_waddr_o); end
      checks++; if (reg_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata_o got %h want 0", reg_wdata_o); end
      checks++; if ({dbus_req, dbus_we, dbus_be} !== 6'h0) begin errors++; $display("FAIL rst_bus_ctl got %b want 0", {dbus_req, dbus_we, dbus_be}); end
      checks++; if ({dbus_addr, dbus_wdata} !== 64'h0) begin errors++; $display("FAIL rst_bus_data got %h want 0", {dbus_addr, dbus_wdata}); end
      in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
   endtask
   task automatic test_lw;
      run_mem(OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 5'd3, 1'b0);
   endtask
   task automatic test_lb_lbu;
      run_mem(OP_LB, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1'b1, 5'd4, 1'b0);
      run_mem(OP_LBU, 32'h103, 32'h0, 32'h80FF_FFFF, 2, 1'b1, 5'd5, 1'b1);
   endtask
   task automatic test_sh;
      run_mem(OP_SH, 32'h102, 32'h1234_ABCD, 32'h0, 1, 1'b1, 5'd6, 1'b0);
   endtask
   task automatic test_passthrough;
      in_valid = 1'b1; alu_op_i = OP_ADDU; mem_addr_i = 32'h100; reg2_data_i = 32'h0;
      reg_waddr_i = 5'd9; reg_we_i = 1'b1; reg_wdata_i = 32'h5;
      #1;
      checks++; if (reg_wdata_o !== 32'h5) begin errors++; $display("FAIL pass_wdata got %h want 5", reg_wdata_o); end
      checks++; if (reg_we_o !== 1'b1) begin errors++; $display("FAIL pass_we got %b want 1", reg_we_o); end
      checks++; if (stall_from_mem !== 1'b0) begin errors++; $display("FAIL pass_stall got %b want 0", stall_from_mem); end
      @(posedge clk); #1;
      checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL pass_req got %b want 0", dbus_req); end
      in_valid = 1'b0;
   endtask
   task automatic test_reset_mid;
      in_valid = 1'b1; alu_op_i = OP_LW; mem_addr_i = 32'h200; reg_we_i = 1'b1; reg_waddr_i = 5'd2;
      @(posedge clk); #1;
      checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL mid_req_before got %b want 1", dbus_req); end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
      checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL mid_req_after got %b want 0", dbus_req); end
      @(posedge clk); #1 dbus_ack = 1'b0;
      checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL late_ack_req got %b want 0", dbus_req); end
      checks++; if (dbus_addr !== 32'h0) begin errors++; $display("FAIL late_ack_addr got %h want 0", dbus_addr); end
      run_mem(OP_LHU, 32'h102, 32'h0, 32'h8001_7FFF, 0, 1'b1, 5'd8, 1'b0);
   endtask
   task automatic test_random;
      logic [7:0] ops [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
      logic [7:0] op;
      logic [31:0] a;
      for (int n = 0; n < 60; n++) begin
         op = ops[$urandom_range(7)];
         a = $urandom;
         if (m_size(op) == 2) a = a & ~32'h1;
         if (m_size(op) == 4) a = a & ~32'h3;
         run_mem(op, a, $urandom, $urandom, int'($urandom_range(3)), 1'($urandom), 5'($urandom), 1'($urandom));
      end
   endtask
`ifdef UNALIGNED_EXC_EN
   task automatic test_unaligned;
      in_valid = 1'b1; alu_op_i = OP_LW; mem_addr_i = 32'h101; reg_we_i = 1'b1;
      #1;
      checks++; if (adel_o !== 1'b1) begin errors++; $display("FAIL adel got %b want 1", adel_o); end
      checks++; if (badvaddr_o !== 32'h101) begin errors++; $display("FAIL badvaddr got %h want 101", badvaddr_o); end
      checks++; if (stall_from_mem !== 1'b0 || reg_we_o !== 1'b0) begin errors++; $display("FAIL unaligned_stall_we got %b%b want 00", stall_from_mem, reg_we_o); end
      @(posedge clk); #1;
      checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL unaligned_req got %b want 0", dbus_req); end
      alu_op_i = OP_SH; mem_addr_i = 32'h103;
      #1;
      checks++; if (ades_o !== 1'b1) begin errors++; $display("FAIL ades got %b want 1", ades_o); end
      @(posedge clk); #1 in_valid = 1'b0;
   endtask
`endif
   initial begin
      test_reset;
      test_lw;
      test_lb_lbu;
      test_sh;
      test_passthrough;
      test_reset_mid;
`ifdef UNALIGNED_EXC_EN
      test_unaligned;
`endif
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
